// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with run-time modulus, variable step, wrap or saturate
// behaviour, synchronous load, terminal-count pulse and sticky boundary flags.
module updown_counter_param #(
  parameter int               WIDTH     = 8,
  parameter int               STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              P_C,
  input  logic              U_D,
  input  logic              MODE,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  D,
  input  logic [WIDTH-1:0]  LIMIT,
  input  logic [STEP_W-1:0] STEP,
  input  logic              CLR_FLAGS,
  output logic [WIDTH-1:0]  Q,
  output logic              TC,
  output logic              OVF,
  output logic              UNF,
  output logic              AT_MAX,
  output logic              AT_ZERO
);

  // STEP may be wider than the count path, so the step clamp is done at whichever is wider
  localparam int CW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

  logic [WIDTH:0]   lim_p1;
  logic [WIDTH:0]   s;
  logic [WIDTH:0]   sum;
  logic [CW-1:0]    step_cw;
  logic [CW-1:0]    lim_cw;
  logic [WIDTH-1:0] q_nxt;
  logic             up_evt;
  logic             dn_evt;

  always_comb begin
    lim_p1  = {1'b0, LIMIT} + {{WIDTH{1'b0}}, 1'b1};
    step_cw = CW'(STEP);
    lim_cw  = CW'(lim_p1);
    s       = (step_cw > lim_cw) ? lim_p1 : step_cw[WIDTH:0];
    sum     = {1'b0, Q} + s;
  end

  always_comb begin
    q_nxt  = Q;
    up_evt = 1'b0;
    dn_evt = 1'b0;
    if (LOAD) begin
      q_nxt = (D > LIMIT) ? LIMIT : D;
    end else if (Q > LIMIT) begin
      q_nxt = LIMIT;
    end else if (P_C) begin
      if (U_D) begin
        if (sum > {1'b0, LIMIT}) begin
          up_evt = 1'b1;
          q_nxt  = MODE ? LIMIT : WIDTH'(sum - lim_p1);
        end else begin
          q_nxt = sum[WIDTH-1:0];
        end
      end else begin
        // Q + LIMIT + 1 fits in WIDTH+1 bits because Q <= LIMIT here
        if ({1'b0, Q} < s) begin
          dn_evt = 1'b1;
          q_nxt  = MODE ? '0 : WIDTH'({1'b0, Q} + lim_p1 - s);
        end else begin
          q_nxt = WIDTH'({1'b0, Q} - s);
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q   <= RESET_VAL;
      TC  <= 1'b0;
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      Q   <= q_nxt;
      TC  <= up_evt | dn_evt;
      OVF <= up_evt | (OVF & ~CLR_FLAGS);
      UNF <= dn_evt | (UNF & ~CLR_FLAGS);
    end
  end

  assign AT_MAX  = (Q == LIMIT);
  assign AT_ZERO = (Q == '0);

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: directed vector table, hand sequences and a
// randomised run against an integer model, all checked through an expectation queue.
module tb_updown_counter_param;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       P_C = 1'b0;
  logic       U_D = 1'b0;
  logic       MODE = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] LIMIT = 8'hFF;
  logic [3:0] STEP = 4'h0;
  logic       CLR_FLAGS = 1'b0;
  logic [7:0] Q;
  logic       TC, OVF, UNF, AT_MAX, AT_ZERO;

  updown_counter_param #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .P_C(P_C), .U_D(U_D), .MODE(MODE), .LOAD(LOAD),
    .D(D), .LIMIT(LIMIT), .STEP(STEP), .CLR_FLAGS(CLR_FLAGS),
    .Q(Q), .TC(TC), .OVF(OVF), .UNF(UNF), .AT_MAX(AT_MAX), .AT_ZERO(AT_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string      name;
    logic       p_c, u_d, mode, load, clr;
    logic [7:0] d, limit;
    logic [3:0] step;
    logic [7:0] q;
    logic       tc, ovf, unf, mx, zr;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] val;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got Q=%h TC=%b OVF=%b UNF=%b MX=%b ZR=%b, expected Q=%h TC=%b OVF=%b UNF=%b MX=%b ZR=%b",
               name, act[12:5], act[4], act[3], act[2], act[1], act[0],
               exp[12:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  function automatic vec_t mk(input string n, input logic pc, input logic ud, input logic md,
                              input logic ld, input logic cl, input logic [7:0] d,
                              input logic [7:0] lim, input logic [3:0] st, input logic [7:0] q,
                              input logic tc, input logic ov, input logic un, input logic mx,
                              input logic zr);
    vec_t v;
    v.name = n; v.p_c = pc; v.u_d = ud; v.mode = md; v.load = ld; v.clr = cl;
    v.d = d; v.limit = lim; v.step = st;
    v.q = q; v.tc = tc; v.ovf = ov; v.unf = un; v.mx = mx; v.zr = zr;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    exp_t e;
    @(negedge CLK);
    RST = 1'b0;
    P_C = v.p_c; U_D = v.u_d; MODE = v.mode; LOAD = v.load; CLR_FLAGS = v.clr;
    D = v.d; LIMIT = v.limit; STEP = v.step;
    e.name = v.name;
    e.val  = {v.q, v.tc, v.ovf, v.unf, v.mx, v.zr};
    exp_q.push_back(e);
  endtask

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.name, {Q, TC, OVF, UNF, AT_MAX, AT_ZERO}, e.val);
    end
  end

  // Reset state with LIMIT=255: Q=0, no flags, AT_ZERO only
  localparam logic [12:0] RST_EXP = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  int         mq, lim, s, cur_lim;
  logic       movf, munf, eu, ed;
  vec_t       v;
  logic [7:0] qv;

  initial begin
    #1 RST = 1'b1;
    #1 chk("reset_init", {Q, TC, OVF, UNF, AT_MAX, AT_ZERO}, RST_EXP);

    for (int i = 1; i <= 35; i++) begin
      qv = 8'(i);
      drive(mk("count_to_23", 1, 1, 0, 0, 0, 8'h00, 8'hFF, 4'd1, qv, 0, 0, 0, 0, 0));
    end
    @(posedge CLK);
    #3 RST = 1'b1;
    #1 chk("async_reset", {Q, TC, OVF, UNF, AT_MAX, AT_ZERO}, RST_EXP);
    drive(mk("first_after_rst", 1, 1, 0, 0, 0, 8'h00, 8'hFF, 4'd1, 8'd1, 0, 0, 0, 0, 0));

    drive(mk("wrap_load0", 0, 0, 0, 1, 0, 8'd0, 8'd9, 4'd0, 8'd0, 0, 0, 0, 0, 1));
    for (int i = 1; i <= 10; i++) begin
      qv = 8'(i % 10);
      drive(mk("wrap_up", 1, 1, 0, 0, 0, 8'd0, 8'd9, 4'd1, qv,
               i == 10, i == 10, 0, qv == 8'd9, qv == 8'd0));
    end
    for (int i = 0; i < 10; i++)
      drive(mk("pause_hold", 0, 1, 0, 0, 0, 8'd0, 8'd9, 4'd1, 8'd0, 0, 1, 0, 0, 1));

    //            name           pc ud md ld cl  d       lim      st     q       tc ov un mx zr
    tbl.push_back(mk("wd_load",   0, 0, 0, 1, 0, 8'd1,   8'd9,   4'd0,  8'd1,   0, 1, 0, 0, 0));
    tbl.push_back(mk("wd_step3",  1, 0, 0, 0, 0, 8'd0,   8'd9,   4'd3,  8'd8,   1, 1, 1, 0, 0));
    tbl.push_back(mk("wd_next",   1, 0, 0, 0, 0, 8'd0,   8'd9,   4'd3,  8'd5,   0, 1, 1, 0, 0));
    tbl.push_back(mk("w2_load",   0, 0, 0, 1, 0, 8'd1,   8'd2,   4'd0,  8'd1,   0, 1, 1, 0, 0));
    tbl.push_back(mk("w2_up15",   1, 1, 0, 0, 0, 8'd0,   8'd2,   4'd15, 8'd1,   1, 1, 1, 0, 0));
    tbl.push_back(mk("w2_dn15",   1, 0, 0, 0, 0, 8'd0,   8'd2,   4'd15, 8'd1,   1, 1, 1, 0, 0));
    tbl.push_back(mk("sat_load",  0, 0, 1, 1, 1, 8'd196, 8'd200, 4'd0,  8'd196, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sat_up",    1, 1, 1, 0, 0, 8'd0,   8'd200, 4'd7,  8'd200, 1, 1, 0, 1, 0));
    tbl.push_back(mk("sat_pin1",  1, 1, 1, 0, 0, 8'd0,   8'd200, 4'd7,  8'd200, 1, 1, 0, 1, 0));
    tbl.push_back(mk("sat_pin2",  1, 1, 1, 0, 0, 8'd0,   8'd200, 4'd7,  8'd200, 1, 1, 0, 1, 0));
    tbl.push_back(mk("sat_ld3",   1, 0, 1, 1, 0, 8'd3,   8'd200, 4'd7,  8'd3,   0, 1, 0, 0, 0));
    tbl.push_back(mk("sat_dn",    1, 0, 1, 0, 0, 8'd0,   8'd200, 4'd7,  8'd0,   1, 1, 1, 0, 1));
    tbl.push_back(mk("sat_dnpin", 1, 0, 1, 0, 0, 8'd0,   8'd200, 4'd7,  8'd0,   1, 1, 1, 0, 1));
    tbl.push_back(mk("ld_clamp",  1, 1, 0, 1, 0, 8'd250, 8'd100, 4'd1,  8'd100, 0, 1, 1, 1, 0));
    tbl.push_back(mk("clamp_p0",  0, 1, 0, 0, 0, 8'd0,   8'd50,  4'd1,  8'd50,  0, 1, 1, 1, 0));
    tbl.push_back(mk("clamp_p1",  1, 1, 0, 0, 0, 8'd0,   8'd20,  4'd1,  8'd20,  0, 1, 1, 1, 0));
    tbl.push_back(mk("clr_evt",   1, 1, 0, 0, 1, 8'd0,   8'd20,  4'd1,  8'd0,   1, 1, 0, 0, 1));
    tbl.push_back(mk("clr_only",  0, 1, 0, 0, 1, 8'd0,   8'd20,  4'd1,  8'd0,   0, 0, 0, 0, 1));
    tbl.push_back(mk("lim0_dn",   1, 0, 0, 0, 0, 8'd0,   8'd0,   4'd5,  8'd0,   1, 0, 1, 1, 1));
    tbl.push_back(mk("lim0_up",   1, 1, 0, 0, 0, 8'd0,   8'd0,   4'd5,  8'd0,   1, 1, 1, 1, 1));
    tbl.push_back(mk("lim0_s0",   1, 1, 0, 0, 0, 8'd0,   8'd0,   4'd0,  8'd0,   0, 1, 1, 1, 1));
    tbl.push_back(mk("s0_hold",   1, 1, 0, 0, 0, 8'd0,   8'd9,   4'd0,  8'd0,   0, 1, 1, 0, 1));
    tbl.push_back(mk("up2",       1, 1, 0, 0, 0, 8'd0,   8'd9,   4'd2,  8'd2,   0, 1, 1, 0, 0));
    tbl.push_back(mk("dn2_exact", 1, 0, 0, 0, 0, 8'd0,   8'd9,   4'd2,  8'd0,   0, 1, 1, 0, 1));
    tbl.push_back(mk("sat_exact", 1, 1, 1, 0, 0, 8'd0,   8'd9,   4'd9,  8'd9,   0, 1, 1, 1, 0));
    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    @(posedge CLK);
    #3 LIMIT = 8'hFF;
    RST = 1'b1;
    #1 chk("async_reset_flags", {Q, TC, OVF, UNF, AT_MAX, AT_ZERO}, RST_EXP);

    mq = 0; movf = 1'b0; munf = 1'b0; cur_lim = 9;
    for (int i = 0; i < 300; i++) begin
      v.name  = "random";
      v.p_c   = ($urandom_range(0, 4) != 0);
      v.u_d   = 1'($urandom_range(0, 1));
      v.mode  = 1'($urandom_range(0, 1));
      v.load  = ($urandom_range(0, 9) == 0);
      v.clr   = ($urandom_range(0, 9) == 0);
      v.d     = 8'($urandom_range(0, 255));
      v.step  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0)
        cur_lim = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255));
      v.limit = 8'(cur_lim);
      lim = cur_lim;
      s   = (int'(v.step) > lim + 1) ? lim + 1 : int'(v.step);
      eu  = 1'b0;
      ed  = 1'b0;
      if (v.load) mq = (int'(v.d) > lim) ? lim : int'(v.d);
      else if (mq > lim) mq = lim;
      else if (v.p_c) begin
        if (v.u_d) begin
          if (mq + s > lim) begin
            eu = 1'b1;
            mq = v.mode ? lim : mq + s - (lim + 1);
          end else mq = mq + s;
        end else begin
          if (mq < s) begin
            ed = 1'b1;
            mq = v.mode ? 0 : mq + (lim + 1) - s;
          end else mq = mq - s;
        end
      end
      movf  = eu | (movf & ~v.clr);
      munf  = ed | (munf & ~v.clr);
      v.q   = 8'(mq);
      v.tc  = eu | ed;
      v.ovf = movf;
      v.unf = munf;
      v.mx  = (mq == lim);
      v.zr  = (mq == 0);
      drive(v);
    end

    @(posedge CLK);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
